// File: rtl/nasti_demux_ordered_if.sv
// rtl/nasti_demux_ordered_if.sv - NASTI channel bundle; LANES=1 upstream, LANES=8 downstream
interface nasti_channel #(
  parameter int LANES      = 1,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [LANES-1:0]                   aw_valid, aw_ready;
  logic [LANES-1:0][ID_WIDTH-1:0]     aw_id;
  logic [LANES-1:0][ADDR_WIDTH-1:0]   aw_addr;
  logic [LANES-1:0][7:0]              aw_len;
  logic [LANES-1:0][USER_WIDTH-1:0]   aw_user;

  logic [LANES-1:0]                   w_valid, w_ready, w_last;
  logic [LANES-1:0][DATA_WIDTH-1:0]   w_data;
  logic [LANES-1:0][DATA_WIDTH/8-1:0] w_strb;
  logic [LANES-1:0][USER_WIDTH-1:0]   w_user;

  logic [LANES-1:0]                   b_valid, b_ready;
  logic [LANES-1:0][ID_WIDTH-1:0]     b_id;
  logic [LANES-1:0][1:0]              b_resp;
  logic [LANES-1:0][USER_WIDTH-1:0]   b_user;

  logic [LANES-1:0]                   ar_valid, ar_ready;
  logic [LANES-1:0][ID_WIDTH-1:0]     ar_id;
  logic [LANES-1:0][ADDR_WIDTH-1:0]   ar_addr;
  logic [LANES-1:0][7:0]              ar_len;
  logic [LANES-1:0][USER_WIDTH-1:0]   ar_user;

  logic [LANES-1:0]                   r_valid, r_ready, r_last;
  logic [LANES-1:0][ID_WIDTH-1:0]     r_id;
  logic [LANES-1:0][DATA_WIDTH-1:0]   r_data;
  logic [LANES-1:0][1:0]              r_resp;
  logic [LANES-1:0][USER_WIDTH-1:0]   r_user;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_user, input aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user, input w_ready,
    input  b_valid, b_id, b_resp, b_user, output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_user, input ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user, output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_user, output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user, output w_ready,
    output b_valid, b_id, b_resp, b_user, input b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_user, output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user, input r_ready
  );
endinterface

// File: rtl/nasti_demux_ordered.sv
// rtl/nasti_demux_ordered.sv - address-decoded 1:8 NASTI demux with in-order responses and DECERR responder
module nasti_demux_ordered #(
  parameter int                            N_PORT          = 8,
  parameter int                            ID_WIDTH        = 1,
  parameter int                            ADDR_WIDTH      = 8,
  parameter int                            DATA_WIDTH      = 8,
  parameter int                            USER_WIDTH      = 1,
  parameter logic [N_PORT*ADDR_WIDTH-1:0]  BASE            = '0,
  parameter logic [N_PORT*ADDR_WIDTH-1:0]  MASK            = '0,
  parameter int                            MAX_OUTSTANDING = 4,
  parameter bit                            DECERR_EN       = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  nasti_channel.slave  s,
  nasti_channel.master m
);
  localparam int         NL      = 8;
  localparam logic [3:0] ERR     = 4'd8;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic {R_IDLE, R_ERR} r_state_t;

  function automatic logic [3:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [3:0] tgt;
    logic       hit;
    tgt = DECERR_EN ? ERR : 4'd0;
    hit = 1'b0;
    for (int i = 0; i < N_PORT; i++) begin
      if (!hit && MASK[i*ADDR_WIDTH +: ADDR_WIDTH] != '0 &&
          (addr & ~MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        tgt = 4'(i);
        hit = 1'b1;
      end
    end
    return tgt;
  endfunction

  logic [3:0]          wr_cnt, rd_cnt, wr_tgt, rd_tgt, w_tgt, aw_tgt, ar_tgt;
  logic                w_lock, err_b_pend;
  logic [ID_WIDTH-1:0] err_b_id, err_r_id;
  logic [7:0]          err_len, err_beat;
  r_state_t            r_state, r_state_nx;
  logic                err_r_valid, err_r_last;
  logic                aw_ok, ar_ok, aw_hs, ar_hs, w_hs, b_hs, r_hs, r_err_hs;

  // A new target is only allowed once the previous target has fully drained,
  // and the error responder only ever holds one transaction per direction.
  always_comb begin
    aw_tgt = decode(s.aw_addr[0]);
    ar_tgt = decode(s.ar_addr[0]);
    aw_ok  = !w_lock && (wr_cnt < MAX_CNT) && (wr_cnt == 4'd0 || aw_tgt == wr_tgt) &&
             (aw_tgt != ERR || wr_cnt == 4'd0);
    ar_ok  = (rd_cnt < MAX_CNT) && (rd_cnt == 4'd0 || ar_tgt == rd_tgt) &&
             (ar_tgt != ERR || rd_cnt == 4'd0);
    s.aw_ready[0] = rstn && aw_ok && ((aw_tgt == ERR) || m.aw_ready[aw_tgt[2:0]]);
    s.ar_ready[0] = rstn && ar_ok && ((ar_tgt == ERR) || m.ar_ready[ar_tgt[2:0]]);
    s.w_ready[0]  = rstn && w_lock && ((w_tgt == ERR) || m.w_ready[w_tgt[2:0]]);
    aw_hs    = s.aw_valid[0] && s.aw_ready[0];
    ar_hs    = s.ar_valid[0] && s.ar_ready[0];
    w_hs     = s.w_valid[0] && s.w_ready[0];
    b_hs     = s.b_valid[0] && s.b_ready[0];
    r_hs     = s.r_valid[0] && s.r_ready[0];
    r_err_hs = r_hs && (rd_tgt == ERR);
  end

  always_comb begin
    if (wr_tgt == ERR) begin
      s.b_valid[0] = rstn && (wr_cnt != 4'd0) && err_b_pend;
      s.b_id[0]    = err_b_id;
      s.b_resp[0]  = 2'b11;
      s.b_user[0]  = '0;
    end else begin
      s.b_valid[0] = rstn && (wr_cnt != 4'd0) && m.b_valid[wr_tgt[2:0]];
      s.b_id[0]    = m.b_id[wr_tgt[2:0]];
      s.b_resp[0]  = m.b_resp[wr_tgt[2:0]];
      s.b_user[0]  = m.b_user[wr_tgt[2:0]];
    end
    if (rd_tgt == ERR) begin
      s.r_valid[0] = rstn && (rd_cnt != 4'd0) && err_r_valid;
      s.r_id[0]    = err_r_id;
      s.r_data[0]  = '0;
      s.r_resp[0]  = 2'b11;
      s.r_last[0]  = err_r_last;
      s.r_user[0]  = '0;
    end else begin
      s.r_valid[0] = rstn && (rd_cnt != 4'd0) && m.r_valid[rd_tgt[2:0]];
      s.r_id[0]    = m.r_id[rd_tgt[2:0]];
      s.r_data[0]  = m.r_data[rd_tgt[2:0]];
      s.r_resp[0]  = m.r_resp[rd_tgt[2:0]];
      s.r_last[0]  = m.r_last[rd_tgt[2:0]];
      s.r_user[0]  = m.r_user[rd_tgt[2:0]];
    end
  end

  // Payloads fan out to every lane; only the valid/ready pair is steered.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      m.aw_id[i]    = s.aw_id[0];
      m.aw_addr[i]  = s.aw_addr[0];
      m.aw_len[i]   = s.aw_len[0];
      m.aw_user[i]  = s.aw_user[0];
      m.ar_id[i]    = s.ar_id[0];
      m.ar_addr[i]  = s.ar_addr[0];
      m.ar_len[i]   = s.ar_len[0];
      m.ar_user[i]  = s.ar_user[0];
      m.w_data[i]   = s.w_data[0];
      m.w_strb[i]   = s.w_strb[0];
      m.w_last[i]   = s.w_last[0];
      m.w_user[i]   = s.w_user[0];
      m.aw_valid[i] = rstn && (i < N_PORT) && s.aw_valid[0] && aw_ok && (aw_tgt == 4'(i));
      m.ar_valid[i] = rstn && (i < N_PORT) && s.ar_valid[0] && ar_ok && (ar_tgt == 4'(i));
      m.w_valid[i]  = rstn && (i < N_PORT) && w_lock && (w_tgt == 4'(i)) && s.w_valid[0];
      m.b_ready[i]  = rstn && (i < N_PORT) && (wr_cnt != 4'd0) && (wr_tgt == 4'(i)) && s.b_ready[0];
      m.r_ready[i]  = rstn && (i < N_PORT) && (rd_cnt != 4'd0) && (rd_tgt == 4'(i)) && s.r_ready[0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wr_tgt     <= '0;
      rd_tgt     <= '0;
      w_tgt      <= '0;
      w_lock     <= 1'b0;
      err_b_pend <= 1'b0;
      err_b_id   <= '0;
      err_r_id   <= '0;
      err_len    <= '0;
      err_beat   <= '0;
    end else begin
      wr_cnt <= wr_cnt + {3'b0, aw_hs} - {3'b0, b_hs};
      rd_cnt <= rd_cnt + {3'b0, ar_hs} - {3'b0, r_hs && s.r_last[0]};
      if (aw_hs) begin
        w_lock <= 1'b1;
        w_tgt  <= aw_tgt;
        wr_tgt <= aw_tgt;
        if (aw_tgt == ERR) err_b_id <= s.aw_id[0];
      end else if (w_hs && s.w_last[0]) begin
        w_lock <= 1'b0;
      end
      if (w_hs && s.w_last[0] && w_tgt == ERR) err_b_pend <= 1'b1;
      else if (b_hs && wr_tgt == ERR)           err_b_pend <= 1'b0;
      if (ar_hs) begin
        rd_tgt <= ar_tgt;
        if (ar_tgt == ERR) begin
          err_r_id <= s.ar_id[0];
          err_len  <= s.ar_len[0];
          err_beat <= '0;
        end
      end else if (r_err_hs) begin
        err_beat <= err_beat + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE: if (ar_hs && ar_tgt == ERR)   r_state_nx = R_ERR;
      R_ERR:  if (r_err_hs && err_r_last)   r_state_nx = R_IDLE;
      default:                              r_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    err_r_valid = (r_state == R_ERR);
    err_r_last  = err_r_valid && (err_beat == err_len);
  end
endmodule

// File: tb/tb_nasti_demux_ordered.sv
// tb/tb_nasti_demux_ordered.sv - decode table, directed corner sequences and randomized read ordering check
module tb_nasti_demux_ordered;
  localparam logic [15:0] BASE = {8'h40, 8'h00};
  localparam logic [15:0] MASK = {8'h3F, 8'h3F};
  localparam logic [3:0]  ERR  = 4'd8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nasti_channel #(.LANES(1)) s_if ();
  nasti_channel #(.LANES(8)) m_if ();

  nasti_demux_ordered #(
    .N_PORT(2), .ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1),
    .BASE(BASE), .MASK(MASK), .MAX_OUTSTANDING(2), .DECERR_EN(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .s(s_if.slave), .m(m_if.master)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [7:0] addr; logic [7:0] exp_valid; logic aw_rdy; logic ar_rdy; } dec_vec_t;
  typedef struct { logic [7:0] addr; logic [7:0] len; logic id; } txn_t;
  typedef struct packed { logic [7:0] data; logic [1:0] resp; logic last; logic id; } beat_t;

  dec_vec_t tbl [10];
  txn_t     lq [2][$];
  beat_t    exp_q [$];
  int       lbeat [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Address map expressed as plain ranges: 0x00-0x3F port 0, 0x40-0x7F port 1, rest unmapped.
  function automatic logic [3:0] ref_tgt(input logic [7:0] a);
    if (a < 8'h40) return 4'd0;
    if (a < 8'h80) return 4'd1;
    return ERR;
  endfunction

  task automatic idle();
    s_if.aw_valid = '0; s_if.aw_id = '0; s_if.aw_addr = '0; s_if.aw_len = '0; s_if.aw_user = '0;
    s_if.w_valid = '0; s_if.w_data = '0; s_if.w_strb = '1; s_if.w_last = '0; s_if.w_user = '0;
    s_if.b_ready = '0;
    s_if.ar_valid = '0; s_if.ar_id = '0; s_if.ar_addr = '0; s_if.ar_len = '0; s_if.ar_user = '0;
    s_if.r_ready = '0;
    m_if.aw_ready = '0; m_if.w_ready = '0; m_if.ar_ready = '0;
    m_if.b_valid = '0; m_if.b_id = '0; m_if.b_resp = '0; m_if.b_user = '0;
    m_if.r_valid = '0; m_if.r_id = '0; m_if.r_data = '0; m_if.r_resp = '0; m_if.r_last = '0; m_if.r_user = '0;
  endtask

  task automatic aw(input logic [7:0] addr, input logic id, input logic [7:0] len);
    s_if.aw_addr[0] = addr; s_if.aw_id[0] = id; s_if.aw_len[0] = len; s_if.aw_valid = 1'b1;
  endtask

  task automatic ar(input logic [7:0] addr, input logic id, input logic [7:0] len);
    s_if.ar_addr[0] = addr; s_if.ar_id[0] = id; s_if.ar_len[0] = len; s_if.ar_valid = 1'b1;
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_m_valid"}, {m_if.aw_valid, m_if.ar_valid, m_if.w_valid}, 32'h0);
    chk({name, "_s_vr"}, {s_if.b_valid, s_if.r_valid, s_if.aw_ready, s_if.ar_ready, s_if.w_ready}, 32'h0);
  endtask

  task automatic random_reads();
    logic       acc;
    logic [3:0] tgt;
    txn_t       t;
    beat_t      e;
    int         issued;
    acc = 1'b0;
    issued = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (acc) begin s_if.ar_valid = 1'b0; acc = 1'b0; end
      if (!s_if.ar_valid[0] && issued < 150 && cyc < 2500 && $urandom_range(0, 2) == 0) begin
        ar(8'($urandom), 1'($urandom), 8'($urandom_range(0, 3)));
        issued++;
      end
      m_if.ar_ready = {6'b0, 2'($urandom)};
      s_if.r_ready  = 1'($urandom);
      m_if.r_valid  = '0;
      for (int k = 0; k < 2; k++) begin
        if (lq[k].size() > 0) begin
          m_if.r_valid[k] = 1'b1;
          m_if.r_data[k]  = lq[k][0].addr + 8'(lbeat[k]);
          m_if.r_resp[k]  = 2'b00;
          m_if.r_last[k]  = (8'(lbeat[k]) == lq[k][0].len);
          m_if.r_id[k]    = lq[k][0].id;
        end
      end
      #1;
      if (s_if.ar_valid[0] && s_if.ar_ready[0]) begin
        acc = 1'b1;
        t.addr = s_if.ar_addr[0]; t.len = s_if.ar_len[0]; t.id = s_if.ar_id[0];
        tgt = ref_tgt(t.addr);
        for (int b = 0; b <= int'(t.len); b++) begin
          e.data = (tgt == ERR) ? 8'h00 : t.addr + 8'(b);
          e.resp = (tgt == ERR) ? 2'b11 : 2'b00;
          e.last = (b == int'(t.len));
          e.id   = t.id;
          exp_q.push_back(e);
        end
        if (tgt == ERR) chk("rnd_ar_route", m_if.ar_valid, 32'h0);
        else begin
          chk("rnd_ar_route", m_if.ar_valid, 32'(1 << tgt));
          lq[int'(tgt)].push_back(t);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (m_if.r_valid[k] && m_if.r_ready[k]) begin
          if (m_if.r_last[k]) begin void'(lq[k].pop_front()); lbeat[k] = 0; end
          else lbeat[k]++;
        end
      end
      if (s_if.r_valid[0] && s_if.r_ready[0]) begin
        if (exp_q.size() == 0) chk("rnd_r_unexpected", 32'h1, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_r_beat", {s_if.r_data[0], s_if.r_resp[0], s_if.r_last[0], s_if.r_id[0]}, 32'(e));
        end
      end
    end
    chk("rnd_drained", 32'(exp_q.size() + lq[0].size() + lq[1].size()), 32'h0);
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'h01, 1'b1, 1'b0};
    tbl[1] = '{8'h3F, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h40, 8'h02, 1'b0, 1'b1};
    tbl[3] = '{8'h44, 8'h02, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'h02, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h90, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'hFF, 8'h00, 1'b1, 1'b1};
    tbl[8] = '{8'h10, 8'h01, 1'b1, 1'b0};
    tbl[9] = '{8'hC0, 8'h00, 1'b1, 1'b1};
    lbeat[0] = 0; lbeat[1] = 0;

    // Reset state with every input pushing to transfer.
    idle();
    @(negedge clk);
    aw(8'h00, 1'b0, 8'd0); ar(8'h40, 1'b0, 8'd0); s_if.w_valid = 1'b1;
    m_if.aw_ready = '1; m_if.ar_ready = '1; m_if.w_ready = '1; m_if.b_valid = '1; m_if.r_valid = '1;
    s_if.b_ready = 1'b1; s_if.r_ready = 1'b1;
    #1 check_quiet("reset");
    @(negedge clk);
    idle();
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      aw(tbl[i].addr, 1'b0, 8'd0); ar(tbl[i].addr, 1'b0, 8'd0);
      m_if.aw_ready = 8'h01; m_if.ar_ready = 8'h02;
      #1;
      chk($sformatf("dec_aw[%0d]", i), {m_if.aw_valid, s_if.aw_ready}, {tbl[i].exp_valid, tbl[i].aw_rdy});
      chk($sformatf("dec_ar[%0d]", i), {m_if.ar_valid, s_if.ar_ready}, {tbl[i].exp_valid, tbl[i].ar_rdy});
      s_if.aw_valid = 1'b0; s_if.ar_valid = 1'b0;
    end

    // Four-beat read to port 1.
    @(negedge clk);
    idle(); ar(8'h44, 1'b0, 8'd3); m_if.ar_ready = 8'h02;
    #1 chk("rd44_route", {m_if.ar_valid, s_if.ar_ready}, {8'h02, 1'b1});
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      s_if.ar_valid = 1'b0; m_if.ar_ready = '0;
      m_if.r_valid = 8'h02; m_if.r_data[1] = 8'hA0 + 8'(b); m_if.r_last[1] = (b == 3); s_if.r_ready = 1'b1;
      #1 chk($sformatf("rd44_beat%0d", b), {s_if.r_valid, s_if.r_data[0], s_if.r_last, m_if.r_ready},
             {1'b1, 8'hA0 + 8'(b), b == 3, 8'h02});
    end

    // Port 0 read outstanding blocks a port 1 read until its last beat.
    @(negedge clk);
    idle(); ar(8'h10, 1'b0, 8'd1); m_if.ar_ready = 8'h01;
    #1 chk("rd10_accept", s_if.ar_ready, 32'h1);
    @(negedge clk);
    ar(8'h50, 1'b0, 8'd0); m_if.ar_ready = 8'h03;
    m_if.r_valid = 8'h01; m_if.r_data[0] = 8'h11; m_if.r_last[0] = 1'b0; s_if.r_ready = 1'b1;
    #1 chk("rd50_stall0", {m_if.ar_valid, s_if.ar_ready}, 32'h0);
    @(negedge clk);
    m_if.r_last[0] = 1'b1;
    #1 chk("rd50_stall1", {m_if.ar_valid, s_if.ar_ready}, 32'h0);
    @(negedge clk);
    m_if.r_valid = '0;
    #1 chk("rd50_accept", {m_if.ar_valid, s_if.ar_ready}, {8'h02, 1'b1});
    @(negedge clk);
    s_if.ar_valid = 1'b0; m_if.r_valid = 8'h02; m_if.r_last[1] = 1'b1; m_if.r_data[1] = 8'h55;
    #1 chk("rd50_beat", {s_if.r_valid, s_if.r_data[0], s_if.r_last}, {1'b1, 8'h55, 1'b1});

    // Unmapped write absorbed by the error responder.
    @(negedge clk);
    idle(); aw(8'h90, 1'b1, 8'd2);
    #1 chk("errw_aw", {m_if.aw_valid, s_if.aw_ready}, {8'h00, 1'b1});
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      s_if.aw_valid = 1'b0; s_if.w_valid = 1'b1; s_if.w_last = (b == 2);
      #1 chk($sformatf("errw_w%0d", b), {m_if.w_valid, s_if.w_ready}, {8'h00, 1'b1});
    end
    @(negedge clk);
    s_if.w_valid = 1'b0;
    #1 chk("errw_b_hold", {s_if.b_valid, s_if.b_id, s_if.b_resp, s_if.b_user}, {1'b1, 1'b1, 2'b11, 1'b0});
    @(negedge clk);
    s_if.b_ready = 1'b1;
    #1 chk("errw_b", {s_if.b_valid, s_if.b_id, s_if.b_resp, s_if.b_user}, {1'b1, 1'b1, 2'b11, 1'b0});
    @(negedge clk);
    #1 chk("errw_b_done", s_if.b_valid, 32'h0);

    // Unmapped two-beat read with backpressure.
    @(negedge clk);
    idle(); ar(8'h90, 1'b0, 8'd1);
    #1 chk("errr_ar", {m_if.ar_valid, s_if.ar_ready}, {8'h00, 1'b1});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_if.ar_valid = 1'b0; s_if.r_ready = (c % 2 == 1);
      #1 chk($sformatf("errr_c%0d", c), {s_if.r_valid, s_if.r_data[0], s_if.r_resp, s_if.r_last, s_if.r_id},
             {1'b1, 8'h00, 2'b11, c >= 2, 1'b0});
    end
    @(negedge clk);
    s_if.r_ready = 1'b0;
    #1 chk("errr_done", s_if.r_valid, 32'h0);

    // Outstanding limit of two writes to port 0.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle(); aw(8'h00, 1'b0, 8'd0); m_if.aw_ready = 8'h01; m_if.w_ready = 8'h01;
      #1 chk($sformatf("lim_aw%0d", k), s_if.aw_ready, 32'h1);
      @(negedge clk);
      s_if.aw_valid = 1'b0; s_if.w_valid = 1'b1; s_if.w_last = 1'b1;
      #1 chk($sformatf("lim_w%0d", k), m_if.w_valid, 32'h01);
    end
    @(negedge clk);
    s_if.w_valid = 1'b0; aw(8'h00, 1'b0, 8'd0);
    #1 chk("lim_aw3_stall", s_if.aw_ready, 32'h0);
    @(negedge clk);
    m_if.b_valid = 8'h01; s_if.b_ready = 1'b1;
    #1 chk("lim_b_same_cycle", {s_if.aw_ready, s_if.b_valid, m_if.b_ready}, {1'b0, 1'b1, 8'h01});
    @(negedge clk);
    m_if.b_valid = '0; s_if.b_ready = 1'b0;
    #1 chk("lim_aw3_accept", s_if.aw_ready, 32'h1);
    @(negedge clk);
    s_if.aw_valid = 1'b0; s_if.w_valid = 1'b1; s_if.w_last = 1'b1;
    @(negedge clk);
    s_if.w_valid = 1'b0; aw(8'h00, 1'b0, 8'd0);
    #1 chk("lim_cnt_two", s_if.aw_ready, 32'h0);
    @(negedge clk);
    s_if.aw_valid = 1'b0; m_if.b_valid = 8'h01; s_if.b_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    idle();

    random_reads();

    // Reset in the middle of a four-beat write burst.
    @(negedge clk);
    idle(); aw(8'h00, 1'b0, 8'd3); m_if.aw_ready = 8'h01; m_if.w_ready = 8'h01;
    @(negedge clk);
    s_if.aw_valid = 1'b0; s_if.w_valid = 1'b1; s_if.w_last = 1'b0;
    @(negedge clk);
    aw(8'h00, 1'b0, 8'd0); ar(8'h00, 1'b0, 8'd0); m_if.ar_ready = '1;
    m_if.b_valid = '1; m_if.r_valid = '1; s_if.b_ready = 1'b1; s_if.r_ready = 1'b1;
    #1 chk("rst_pre_w2", m_if.w_valid, 32'h01);
    #2 rstn = 1'b0;
    #1 check_quiet("rst_async");
    @(negedge clk);
    idle(); rstn = 1'b1; aw(8'h40, 1'b0, 8'd0); m_if.aw_ready = 8'h02;
    #1 chk("rst_release_aw", {m_if.aw_valid, s_if.aw_ready, s_if.w_ready}, {8'h02, 1'b1, 1'b0});
    @(negedge clk);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
